gfx_shift_sequencer: RTL and testbench
======================================

GFX_SHIFT_SEQUENCER -- requirements
Module: gfx_shift_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, ROM byte address width.
REQ-002 SHALL have parameter CNT_W, default 6, width of per-line byte count.
REQ-003 SHALL have ports, clock and reset first:
  clk  in  1  system clock; all state changes on rising edge.
  Reset_n  in  1  reset, synchronous, active-low.
  pix_cen  in  1  pixel clock enable, one clk wide; also the shifter's clock enable.
  line_start  in  1  one-clk pulse; starts a line run.
  abort  in  1  one-clk pulse; terminates the run.
  base_addr  in  ADDR_W  first ROM byte address, sampled on accepted line_start.
  byte_count  in  CNT_W  bytes in the line, sampled on accepted line_start.
  flip  in  1  bit-reverse graphics bytes, sampled on accepted line_start.
  rom_req  out  1  ROM fetch request.
  rom_addr  out  ADDR_W  ROM fetch address.
  rom_ack  in  1  ROM data valid, one clk.
  rom_data  in  8  ROM byte, valid with rom_ack.
  sh_ldn  out  1  shifter SH_LDn; 0 = parallel load on this pix_cen.
  sh_data  out  8  shifter parallel data D[7:0].
  inh  out  1  shifter clock inhibit.
  clr_n  out  1  shifter clear, active-low.
  busy  out  1  run in progress.
  done  out  1  one-clk pulse at run end.
  underrun  out  1  sticky: a load slot found no data.

Function
REQ-004 SHALL implement states IDLE, PRIME, RUN.
REQ-005 IDLE: line_start with byte_count != 0 SHALL latch inputs, set remaining = byte_count, set addr = base_addr, clear underrun, and go to PRIME.
REQ-006 IDLE: line_start with byte_count == 0 SHALL produce a done pulse on the next clk and stay in IDLE.
REQ-007 line_start while busy SHALL be ignored.
REQ-008 Fetch engine: rom_req SHALL rise when the hold register is empty and the fetched count is less than byte_count.
REQ-009 Fetch engine: rom_addr SHALL be held stable while rom_req = 1.
REQ-010 Fetch engine: on the clk with rom_req=1 and rom_ack=1, the block SHALL write rom_data (bit-reversed if flip) to the hold register, set hold valid, increment addr by 1 modulo 2^ADDR_W, and drop rom_req on the next clk.
REQ-011 rom_ack while rom_req = 0 SHALL be ignored.
REQ-012 PRIME: when hold becomes valid, SHALL go to RUN with phase = 0.
REQ-013 PRIME SHALL never set underrun.
REQ-014 RUN: phase (3-bit) SHALL advance on pix_cen, 7 wrapping to 0.
REQ-015 RUN: at phase 0 with hold valid and remaining != 0, sh_ldn SHALL be 0 and sh_data SHALL equal the hold register.
REQ-016 On pix_cen in that slot, the block SHALL clear hold valid and decrement remaining; sh_ldn SHALL return to 1 on the next clk.
REQ-017 sh_ldn SHALL be 1 at all other times.
REQ-018 Underrun: at phase 0 with hold empty and remaining != 0, inh SHALL be 1 and phase SHALL hold.
REQ-019 Underrun: underrun SHALL set on the first pix_cen of that stall.
REQ-020 Underrun: when hold becomes valid, inh SHALL drop and the load SHALL occur on the next pix_cen.
REQ-021 Run end: on the pix_cen with remaining == 0 and phase 7, the block SHALL pulse done and clr_n (both 0→active for one clk) and return to IDLE.
REQ-022 Run end: the last byte SHALL be shifted exactly 7 times after its load.
REQ-023 busy SHALL be 1 in PRIME and RUN, and 0 in IDLE.
REQ-024 abort SHALL, on the next clk, force IDLE, rom_req 0, sh_ldn 1, inh 0, hold invalid, and pulse clr_n for one clk; done SHALL not pulse.
REQ-025 A rom_ack arriving after abort SHALL be discarded.
REQ-026 abort and line_start in the same clk SHALL give abort priority.
REQ-027 pix_cen is asynchronous to the fetch handshake; a fetch completing on the same clk as a phase-0 pix_cen SHALL NOT load that clk and SHALL NOT count as underrun if hold becomes valid before the load slot is evaluated in the next clk.

Reset
REQ-028 Reset_n = 0 at a clk edge SHALL force IDLE and phase 0.
REQ-029 Reset_n = 0 SHALL force outputs: rom_req 0, rom_addr 0, sh_ldn 1, sh_data 0x00, inh 0, clr_n 1, busy 0, done 0, underrun 0.
REQ-030 Reset_n = 0 SHALL clear hold valid and counters, overriding all other inputs including an in-flight handshake.

Verification
REQ-031 base=0x1000, count=2, flip=0, ROM acks in 1 clk, pix_cen every 4 clk -> addrs 0x1000, 0x1001 fetched; two loads 8 pix_cen apart; done 15 pix_cen after first load; underrun 0.
REQ-032 flip=1, rom_data=0x81 then 0x0F -> sh_data 0x81 then 0xF0 at the load slots.
REQ-033 ROM ack delayed 40 clk for the 2nd byte, pix_cen every 2 clk -> inh=1 stall at phase 0, underrun=1, load resumes on first pix_cen after ack, no pixels lost.
REQ-034 abort asserted mid-fetch, then late rom_ack -> IDLE next clk, clr_n pulse, no done, hold stays invalid, next line_start starts cleanly.
REQ-035 count=0 line_start -> done pulse, no rom_req; line_start while busy -> ignored; base=0xFFFF, count=2 -> second addr 0x0000.
REQ-036 Reset_n=0 mid-RUN with rom_req high -> all outputs at reset values on the next clk.

Source files
------------

// File: rtl/gfx_shift_sequencer.sv
// Line fetch/shift sequencer: pulls graphics bytes from ROM into a hold
// register and feeds them to an external 8-bit shifter on pixel slots.
module gfx_shift_sequencer #(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              Reset_n,
  input  logic              pix_cen,
  input  logic              line_start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  byte_count,
  input  logic              flip,
  output logic              rom_req,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic              rom_ack,
  input  logic [7:0]        rom_data,
  output logic              sh_ldn,
  output logic [7:0]        sh_data,
  output logic              inh,
  output logic              clr_n,
  output logic              busy,
  output logic              done,
  output logic              underrun
);

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    RUN
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [2:0]        phase_q;
  logic [CNT_W-1:0]  remain_q;
  logic [CNT_W-1:0]  fetched_q;
  logic [CNT_W-1:0]  count_q;
  logic              flip_q;
  logic [ADDR_W-1:0] addr_q;
  logic              req_q;
  logic [7:0]        hold_q;
  logic              hold_v;
  logic              done_q;
  logic              clr_n_q;
  logic              ur_q;

  logic              in_run;
  logic              slot;
  logic              load_slot;
  logic              stall;
  logic              load;
  logic              run_end;
  logic              ack_ok;
  logic              start_ok;
  logic [7:0]        rom_rev;

  always_comb begin
    rom_rev = '0;
    for (int i = 0; i < 8; i++)
      rom_rev[i] = rom_data[7-i];
  end

  assign ack_ok    = req_q & rom_ack;
  assign in_run    = (state_q == RUN);
  assign slot      = in_run & (phase_q == 3'd0)
                   & (remain_q != '0);
  assign load_slot = slot & hold_v;
  assign stall     = slot & ~hold_v;
  assign load      = load_slot & pix_cen;
  assign run_end   = in_run & pix_cen
                   & (remain_q == '0)
                   & (phase_q == 3'd7);
  assign start_ok  = (state_q == IDLE) & line_start
                   & (byte_count != '0);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_ok) state_d = PRIME;
      PRIME:   if (hold_v)   state_d = RUN;
      RUN:     if (run_end)  state_d = IDLE;
      default:               state_d = IDLE;
    endcase
    if (abort)
      state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!Reset_n) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      remain_q  <= '0;
      fetched_q <= '0;
      count_q   <= '0;
      flip_q    <= 1'b0;
      addr_q    <= '0;
      req_q     <= 1'b0;
      hold_q    <= '0;
      hold_v    <= 1'b0;
      done_q    <= 1'b0;
      clr_n_q   <= 1'b1;
      ur_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      clr_n_q <= 1'b1;
      if (abort) begin
        req_q   <= 1'b0;
        hold_v  <= 1'b0;
        phase_q <= '0;
        clr_n_q <= 1'b0;
      end else begin
        if (state_q == IDLE && line_start) begin
          if (byte_count == '0) begin
            done_q <= 1'b1;
          end else begin
            count_q   <= byte_count;
            remain_q  <= byte_count;
            fetched_q <= '0;
            addr_q    <= base_addr;
            flip_q    <= flip;
            ur_q      <= 1'b0;
            phase_q   <= '0;
            hold_v    <= 1'b0;
          end
        end
        // ack and load never coincide: req only rises with hold empty
        if (ack_ok) begin
          hold_q    <= flip_q ? rom_rev : rom_data;
          hold_v    <= 1'b1;
          addr_q    <= addr_q + 1'b1;
          fetched_q <= fetched_q + 1'b1;
          req_q     <= 1'b0;
        end else if (state_q != IDLE && !req_q
                     && !hold_v && fetched_q < count_q) begin
          req_q <= 1'b1;
        end
        if (load) begin
          hold_v   <= 1'b0;
          remain_q <= remain_q - 1'b1;
        end
        if (state_q == PRIME)
          phase_q <= '0;
        if (in_run && pix_cen && !stall)
          phase_q <= phase_q + 3'd1;
        if (stall && pix_cen && !ack_ok)
          ur_q <= 1'b1;
        if (run_end) begin
          done_q  <= 1'b1;
          clr_n_q <= 1'b0;
        end
      end
    end
  end

  assign rom_req  = req_q;
  assign rom_addr = addr_q;
  assign sh_ldn   = ~load_slot;
  assign sh_data  = hold_q;
  assign inh      = stall;
  assign clr_n    = clr_n_q;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign underrun = ur_q;

endmodule

// File: tb/tb_gfx_shift_sequencer.sv
// Directed bench for gfx_shift_sequencer: table of two-byte lines plus
// hand sequences for zero count, busy restart, abort and reset.
module tb_gfx_shift_sequencer;

  logic        clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        pix_cen = 1'b0;
  logic        line_start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] base_addr = '0;
  logic [5:0]  byte_count = '0;
  logic        flip = 1'b0;
  logic        rom_req;
  logic [15:0] rom_addr;
  logic        rom_ack = 1'b0;
  logic [7:0]  rom_data = '0;
  logic        sh_ldn;
  logic [7:0]  sh_data;
  logic        inh;
  logic        clr_n;
  logic        busy;
  logic        done;
  logic        underrun;

  gfx_shift_sequencer #(.ADDR_W(16), .CNT_W(6)) dut (
    .clk(clk), .Reset_n(Reset_n), .pix_cen(pix_cen),
    .line_start(line_start), .abort(abort),
    .base_addr(base_addr), .byte_count(byte_count), .flip(flip),
    .rom_req(rom_req), .rom_addr(rom_addr),
    .rom_ack(rom_ack), .rom_data(rom_data),
    .sh_ldn(sh_ldn), .sh_data(sh_data), .inh(inh),
    .clr_n(clr_n), .busy(busy), .done(done), .underrun(underrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] base;
    logic [5:0]  cnt;
    logic        flp;
    int          per;
    int          dly0;
    int          dly1;
    logic [7:0]  d0;
    logic [7:0]  d1;
    logic [7:0]  s0;
    logic [7:0]  s1;
    logic [15:0] a0;
    logic [15:0] a1;
    logic        ur;
  } vec_t;

  localparam logic [30:0] RST_VEC =
    {1'b0, 16'h0000, 1'b1, 8'h00, 1'b0, 1'b1, 3'b000};

  int checks = 0;
  int errors = 0;

  // pixel enable generator
  int pix_per = 4;
  int pcnt = 0;
  always @(posedge clk) begin
    #2;
    if (pcnt >= pix_per - 1) begin
      pix_cen = 1'b1;
      pcnt = 0;
    end else begin
      pix_cen = 1'b0;
      pcnt++;
    end
  end

  // ROM responder
  logic [7:0]  mem [4];
  int          dly [4];
  int          resp_base = 0;
  int          resp_cnt = 0;
  int          age = 0;
  int          ri;
  logic        resp_en = 1'b1;
  logic        force_ack = 1'b0;
  logic [15:0] addr_log [$];
  always @(posedge clk) begin
    #2;
    if (force_ack) begin
      rom_ack = 1'b1;
      rom_data = 8'hEE;
      age = 0;
    end else if (rom_ack) begin
      rom_ack = 1'b0;
    end else if (rom_req && resp_en) begin
      age++;
      ri = resp_cnt - resp_base;
      if (ri >= 0 && ri < 4 && age >= dly[ri]) begin
        rom_ack = 1'b1;
        rom_data = mem[ri];
        addr_log.push_back(rom_addr);
        resp_cnt++;
        age = 0;
      end
    end else begin
      age = 0;
    end
  end

  // monitor: values seen here are what the DUT samples next edge
  int         pix_idx = 0;
  int         ld_pix [$];
  logic [7:0] ld_dat [$];
  int         ack_pix = 0;
  int         done_cnt = 0;
  int         done_pix = 0;
  int         inh_cnt = 0;
  int         clrn_cnt = 0;
  int         req_cnt = 0;
  always @(negedge clk) begin
    if (pix_cen) pix_idx++;
    if (pix_cen && !sh_ldn) begin
      ld_pix.push_back(pix_idx);
      ld_dat.push_back(sh_data);
    end
    if (rom_ack && rom_req) ack_pix = pix_idx;
    if (done) begin
      done_cnt++;
      done_pix = pix_idx;
    end
    if (inh) inh_cnt++;
    if (!clr_n) clrn_cnt++;
    if (rom_req) req_cnt++;
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [30:0] out_vec();
    return {rom_req, rom_addr, sh_ldn, sh_data,
            inh, clr_n, busy, done, underrun};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int l0, a0, dn0, ih0, c0;

  task automatic launch(input vec_t v);
    pix_per = v.per;
    mem[0] = v.d0;
    mem[1] = v.d1;
    dly[0] = v.dly0;
    dly[1] = v.dly1;
    resp_base = resp_cnt;
    l0 = ld_pix.size();
    a0 = addr_log.size();
    dn0 = done_cnt;
    ih0 = inh_cnt;
    c0 = clrn_cnt;
    base_addr = v.base;
    byte_count = v.cnt;
    flip = v.flp;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
  endtask

  task automatic finish_line(input string nm, input vec_t v);
    int lp0, lp1;
    bit ok;
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (done_cnt > dn0) begin
        ok = 1;
        break;
      end
    end
    chk({nm, "_timeout"}, ok, 1);
    tick();
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_nload"}, ld_pix.size() - l0, 2);
    chk({nm, "_nfetch"}, addr_log.size() - a0, 2);
    chk({nm, "_ndone"}, done_cnt - dn0, 1);
    chk({nm, "_nclr"}, clrn_cnt - c0, 1);
    chk({nm, "_ur"}, underrun, v.ur);
    chk({nm, "_inh"}, (inh_cnt > ih0), v.ur);
    if (addr_log.size() >= a0 + 2) begin
      chk({nm, "_addr0"}, addr_log[a0], v.a0);
      chk({nm, "_addr1"}, addr_log[a0+1], v.a1);
    end
    if (ld_pix.size() >= l0 + 2) begin
      lp0 = ld_pix[l0];
      lp1 = ld_pix[l0+1];
      chk({nm, "_sh0"}, ld_dat[l0], v.s0);
      chk({nm, "_sh1"}, ld_dat[l0+1], v.s1);
      chk({nm, "_donepix"}, done_pix, lp1 + 7);
      if (v.ur) begin
        chk({nm, "_gap_gt8"}, (lp1 - lp0 > 8), 1);
        chk({nm, "_resume"}, lp1, ack_pix + 1);
      end else begin
        chk({nm, "_gap"}, lp1 - lp0, 8);
      end
    end
  endtask

  vec_t vecs [5];
  vec_t bv;

  initial begin
    vecs[0] = '{16'h1000, 6'd2, 1'b0, 4, 1, 1,
                8'h3C, 8'hA5, 8'h3C, 8'hA5, 16'h1000, 16'h1001, 1'b0};
    vecs[1] = '{16'h2000, 6'd2, 1'b1, 4, 1, 1,
                8'h81, 8'h0F, 8'h81, 8'hF0, 16'h2000, 16'h2001, 1'b0};
    vecs[2] = '{16'hFFFF, 6'd2, 1'b0, 4, 1, 1,
                8'h12, 8'h34, 8'h12, 8'h34, 16'hFFFF, 16'h0000, 1'b0};
    vecs[3] = '{16'h0800, 6'd2, 1'b0, 3, 3, 3,
                8'h5A, 8'h01, 8'h5A, 8'h01, 16'h0800, 16'h0801, 1'b0};
    vecs[4] = '{16'h0040, 6'd2, 1'b1, 2, 1, 40,
                8'h55, 8'hC3, 8'hAA, 8'hC3, 16'h0040, 16'h0041, 1'b1};

    repeat (3) tick();
    chk("reset_outs", out_vec(), RST_VEC);
    Reset_n = 1'b1;
    tick();
    chk("post_reset_outs", out_vec(), RST_VEC);

    // zero-length line
    dn0 = done_cnt;
    base_addr = 16'h1234;
    byte_count = 6'd0;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    tick();
    chk("zero_done_width", done, 0);
    repeat (4) tick();
    chk("zero_no_req", req_cnt, 0);

    for (int i = 0; i < 5; i++) begin
      launch(vecs[i]);
      finish_line($sformatf("row%0d", i), vecs[i]);
    end

    // line_start while busy is ignored
    bv = '{16'h3000, 6'd2, 1'b0, 4, 1, 1,
           8'h11, 8'h22, 8'h11, 8'h22, 16'h3000, 16'h3001, 1'b0};
    launch(bv);
    repeat (5) tick();
    base_addr = 16'h5000;
    byte_count = 6'd3;
    flip = 1'b1;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    finish_line("busy_ign", bv);

    // abort mid-fetch, then a late ack
    resp_en = 1'b0;
    launch(vecs[0]);
    for (int i = 0; i < 20 && !rom_req; i++) tick();
    chk("abort_req_up", rom_req, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_req", rom_req, 0);
    chk("abort_clr", clr_n, 0);
    chk("abort_ldn", sh_ldn, 1);
    chk("abort_inh", inh, 0);
    force_ack = 1'b1;
    tick();
    force_ack = 1'b0;
    chk("abort_clr_width", clr_n, 1);
    repeat (3) tick();
    chk("abort_late_busy", busy, 0);
    chk("abort_late_req", rom_req, 0);
    chk("abort_no_done", done_cnt - dn0, 0);

    // abort wins over a simultaneous line_start
    base_addr = 16'h6000;
    byte_count = 6'd2;
    line_start = 1'b1;
    abort = 1'b1;
    tick();
    line_start = 1'b0;
    abort = 1'b0;
    chk("prio_busy", busy, 0);
    chk("prio_clr", clr_n, 0);
    repeat (3) tick();

    // clean restart after abort
    resp_en = 1'b1;
    launch(vecs[1]);
    finish_line("restart", vecs[1]);

    // reset mid-run with a fetch outstanding
    launch(vecs[4]);
    for (int i = 0; i < 500; i++) begin
      if (rom_req && ld_pix.size() > l0) break;
      tick();
    end
    chk("mid_req_up", rom_req, 1);
    Reset_n = 1'b0;
    tick();
    chk("mid_reset_outs", out_vec(), RST_VEC);
    Reset_n = 1'b1;
    repeat (3) tick();
    chk("post_mid_reset_outs", out_vec(), RST_VEC);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
